// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port synchronous memory between an instruction-fetch
// port and a data port; data has priority, a starvation counter guarantees fetch progress.
module mem_port_arbiter #(
  parameter int MEM_AW   = 6,
  parameter int LAT      = 1,
  parameter int MAX_DATA = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = 3;
  localparam int SW     = $clog2(MAX_DATA + 1);
  localparam logic [CNT_W-1:0] LAT_M1    = CNT_W'(LAT - 1);
  localparam logic [SW-1:0]    STARV_MAX = SW'(MAX_DATA);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [SW-1:0]       r_starv;
  logic                r_src_d;
  logic                r_we;

  logic                r_mem_en;
  logic                r_mem_we;
  logic [MEM_AW-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_if_ready;
  logic                r_d_ready;
  logic                r_busy;

  logic                w_dreq;
  logic                w_fetch_forced;
  logic                w_grant_d;
  logic                w_grant_i;
  logic                w_capture;
  logic [31:0]         w_addr_sel;
  logic                w_unused_addr;

  assign w_dreq         = d_read | d_write;
  assign w_fetch_forced = (r_starv == STARV_MAX) && if_req;
  assign w_addr_sel     = w_grant_d ? d_addr : if_addr;
  // Byte offset and bits above the word range are deliberately dropped (address wrap).
  assign w_unused_addr  = &{1'b0, w_addr_sel[31:MEM_AW+2], w_addr_sel[1:0]};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant_d   = 1'b0;
    w_grant_i   = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_dreq && !w_fetch_forced) begin
          w_grant_d   = 1'b1;
          w_state_nxt = S_ACCESS;
        end else if (if_req) begin
          w_grant_i   = 1'b1;
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (r_we) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = LAT_M1;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_starv     <= '0;
      r_src_d     <= 1'b0;
      r_we        <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_ready  <= 1'b0;
      r_d_ready   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;

      if (w_grant_d || w_grant_i) begin
        r_src_d    <= w_grant_d;
        r_we       <= w_grant_d & d_write;
        r_mem_addr <= w_addr_sel[MEM_AW+1:2];
      end
      if (w_grant_d) begin
        r_mem_wdata <= d_wdata;
      end

      // Only contested data grants count towards starving the fetch port.
      if (w_grant_i) begin
        r_starv <= '0;
      end else if (w_grant_d && if_req && (r_starv != STARV_MAX)) begin
        r_starv <= r_starv + 1'b1;
      end

      if (w_capture) begin
        if (r_src_d) begin
          r_d_rdata <= mem_rdata;
        end else begin
          r_if_rdata <= mem_rdata;
        end
      end

      r_mem_en   <= w_grant_d | w_grant_i;
      r_mem_we   <= w_grant_d & d_write;
      r_d_ready  <= (w_state_nxt == S_DONE) &  r_src_d;
      r_if_ready <= (w_state_nxt == S_DONE) & ~r_src_d;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign if_ready  = r_if_ready;
  assign d_ready   = r_d_ready;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (LAT=1 and LAT=3) with a behavioural
// memory and a transaction-level arbitration/data model.
module tb_mem_port_arbiter;

  localparam int MAXD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [2];
  logic        if_req    [2];
  logic [31:0] if_addr   [2];
  logic [31:0] if_rdata  [2];
  logic        if_ready  [2];
  logic        d_read    [2];
  logic        d_write   [2];
  logic [31:0] d_addr    [2];
  logic [31:0] d_wdata   [2];
  logic [31:0] d_rdata   [2];
  logic        d_ready   [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [5:0]  mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        busy      [2];

  int nvec = 0;
  int nerr = 0;

  logic [31:0] ref_mem [2][64];
  logic [31:0] exp_ird [2];
  logic [31:0] exp_drd [2];
  int          starv   [2];

  function automatic logic [31:0] init_word(input int a);
    return 32'h8c03_0000 + 32'(2 * a);
  endfunction

  function automatic int lat(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_u
    localparam int L = (g == 0) ? 1 : 3;

    mem_port_arbiter #(.MEM_AW(6), .LAT(L), .MAX_DATA(MAXD)) u_dut (
      .clk(clk), .rst_n(rst_n[g]),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_rdata(if_rdata[g]), .if_ready(if_ready[g]),
      .d_read(d_read[g]), .d_write(d_write[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_rdata(d_rdata[g]), .d_ready(d_ready[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]), .busy(busy[g])
    );

    logic [31:0] wd [64];
    bit          wf [64];
    logic [31:0] pd [L];
    bit          pv [L];
    logic [31:0] garb;

    // Memory macro: read data appears LAT cycles after mem_en, garbage otherwise.
    always @(posedge clk) begin
      garb  <= $urandom;
      pv[0] <= mem_en[g] && !mem_we[g];
      pd[0] <= wf[mem_addr[g]] ? wd[mem_addr[g]] : init_word(int'(mem_addr[g]));
      if (mem_en[g] && mem_we[g]) begin
        wd[mem_addr[g]] <= mem_wdata[g];
        wf[mem_addr[g]] <= 1'b1;
      end
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
    assign mem_rdata[g] = pv[L-1] ? pd[L-1] : garb;
  end

  task automatic apply(input int u, input bit pi, input bit pdq, input bit drd, input bit dwr,
                       input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dw);
    if_req[u]  = pi;
    if_addr[u] = ia;
    d_read[u]  = pdq && drd;
    d_write[u] = pdq && dwr;
    d_addr[u]  = da;
    d_wdata[u] = dw;
  endtask

  task automatic rand_dkind(output bit drd, output bit dwr);
    int k;
    k = $urandom_range(0, 2);
    drd = (k != 1);
    dwr = (k != 0);
  endtask

  task automatic check_all_zero(input int u, input string name);
    logic [106:0] v;
    v = {mem_en[u], mem_we[u], mem_addr[u], mem_wdata[u], if_rdata[u], d_rdata[u],
         if_ready[u], d_ready[u], busy[u]};
    nvec++;
    if (v !== '0) begin
      nerr++;
      $display("FAIL %s u%0d: outputs=%h, required all zero", name, u, v);
    end
  endtask

  // Single transaction from idle. kind: 0 fetch, 1 data read, 2 data write, 3 read+write.
  task automatic txn(input int u, input int kind, input logic [31:0] addr,
                     input logic [31:0] wdata, input string name);
    bit          isd;
    bit          we;
    int          n;
    logic [5:0]  ma;
    logic [31:0] expv;
    isd = (kind != 0);
    we  = (kind >= 2);
    n   = we ? 2 : 2 + lat(u);
    ma  = addr[7:2];
    @(negedge clk);
    apply(u, !isd, isd, (kind == 1 || kind == 3), we, addr, addr, wdata);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (c == 1) begin
        nvec++;
        if (mem_en[u] !== 1'b1 || mem_we[u] !== we || mem_addr[u] !== ma || busy[u] !== 1'b1) begin
          nerr++;
          $display("FAIL %s access: en=%b we=%b addr=%0d busy=%b, required en=1 we=%b addr=%0d busy=1",
                   name, mem_en[u], mem_we[u], mem_addr[u], busy[u], we, ma);
        end
        if (we) begin
          nvec++;
          if (mem_wdata[u] !== wdata) begin
            nerr++;
            $display("FAIL %s wdata: got %h, required %h", name, mem_wdata[u], wdata);
          end
        end
      end else begin
        nvec++;
        if (mem_en[u] !== 1'b0) begin
          nerr++;
          $display("FAIL %s mem_en cycle %0d: got %b, required 0", name, c, mem_en[u]);
        end
      end
      if (c < n) begin
        nvec++;
        if ((if_ready[u] | d_ready[u]) !== 1'b0) begin
          nerr++;
          $display("FAIL %s early ready cycle %0d: if=%b d=%b, required 0", name, c, if_ready[u], d_ready[u]);
        end
      end
    end
    nvec++;
    if (if_ready[u] !== !isd || d_ready[u] !== isd) begin
      nerr++;
      $display("FAIL %s ready: if=%b d=%b, required if=%b d=%b", name, if_ready[u], d_ready[u], !isd, isd);
    end
    if (!isd) begin
      expv = ref_mem[u][ma];
      exp_ird[u] = expv;
      starv[u] = 0;
      nvec++;
      if (if_rdata[u] !== expv) begin
        nerr++;
        $display("FAIL %s if_rdata: got %h, required %h", name, if_rdata[u], expv);
      end
    end else begin
      if (we) ref_mem[u][ma] = wdata;
      else exp_drd[u] = ref_mem[u][ma];
      nvec++;
      if (d_rdata[u] !== exp_drd[u]) begin
        nerr++;
        $display("FAIL %s d_rdata: got %h, required %h", name, d_rdata[u], exp_drd[u]);
      end
    end
    apply(u, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    nvec++;
    if (busy[u] !== 1'b0 || if_ready[u] !== 1'b0 || d_ready[u] !== 1'b0) begin
      nerr++;
      $display("FAIL %s idle after done: busy=%b if=%b d=%b, required 0", name, busy[u], if_ready[u], d_ready[u]);
    end
  endtask

  // Continuous request stream; hold_both keeps both requesters permanently asking.
  task automatic run_seq(input int u, input int ntx, input bit hold_both, input string name);
    bit          pi, pdq, drd, dwr, gd, we;
    logic [31:0] ia, da, dw, expv;
    logic [5:0]  ma;
    int          base, gap, cacc;
    pi = 1; pdq = 1; drd = 1; dwr = 0;
    ia = $urandom; da = $urandom; dw = $urandom;
    if (!hold_both) begin
      pi  = bit'($urandom_range(0, 1));
      pdq = !pi || bit'($urandom_range(0, 1));
      rand_dkind(drd, dwr);
    end
    @(negedge clk);
    apply(u, pi, pdq, drd, dwr, ia, da, dw);
    base = 2;
    for (int t = 0; t < ntx; t++) begin
      gd   = pdq && !(starv[u] == MAXD && pi);
      we   = gd && dwr;
      gap  = base + (we ? 0 : lat(u));
      cacc = base - 1;
      ma   = gd ? da[7:2] : ia[7:2];
      for (int c = 1; c <= gap; c++) begin
        @(negedge clk);
        if (c == cacc) begin
          nvec++;
          if (mem_en[u] !== 1'b1 || mem_addr[u] !== ma || mem_we[u] !== we) begin
            nerr++;
            $display("FAIL %s t%0d access: en=%b addr=%0d we=%b, required en=1 addr=%0d we=%b",
                     name, t, mem_en[u], mem_addr[u], mem_we[u], ma, we);
          end
        end
        if (c < gap) begin
          nvec++;
          if ((if_ready[u] | d_ready[u]) !== 1'b0) begin
            nerr++;
            $display("FAIL %s t%0d early ready cycle %0d: if=%b d=%b", name, t, c, if_ready[u], d_ready[u]);
          end
        end
      end
      nvec++;
      if (d_ready[u] !== gd || if_ready[u] !== !gd) begin
        nerr++;
        $display("FAIL %s t%0d grant: if_ready=%b d_ready=%b, required if=%b d=%b",
                 name, t, if_ready[u], d_ready[u], !gd, gd);
      end
      if (!gd) begin
        expv = ref_mem[u][ma];
        exp_ird[u] = expv;
        starv[u] = 0;
        nvec++;
        if (if_rdata[u] !== expv) begin
          nerr++;
          $display("FAIL %s t%0d if_rdata: got %h, required %h", name, t, if_rdata[u], expv);
        end
      end else begin
        if (we) ref_mem[u][ma] = dw;
        else exp_drd[u] = ref_mem[u][ma];
        if (pi && starv[u] < MAXD) starv[u]++;
        nvec++;
        if (d_rdata[u] !== exp_drd[u]) begin
          nerr++;
          $display("FAIL %s t%0d d_rdata: got %h, required %h", name, t, d_rdata[u], exp_drd[u]);
        end
      end
      if (gd) pdq = 0; else pi = 0;
      if (t == ntx - 1) begin
        pi = 0; pdq = 0;
      end else if (hold_both) begin
        if (gd) begin pdq = 1; da = $urandom; end
        else begin pi = 1; ia = $urandom; end
      end else begin
        if (!pi && $urandom_range(0, 1) == 1) begin pi = 1; ia = $urandom; end
        if (!pdq && $urandom_range(0, 1) == 1) begin
          pdq = 1; da = $urandom; dw = $urandom; rand_dkind(drd, dwr);
        end
        if (!pi && !pdq) begin pi = 1; ia = $urandom; end
      end
      apply(u, pi, pdq, drd, dwr, ia, da, dw);
      base = 3;
    end
    @(negedge clk);
    nvec++;
    if (busy[u] !== 1'b0) begin
      nerr++;
      $display("FAIL %s final idle: busy=%b, required 0", name, busy[u]);
    end
  endtask

  task automatic test_reset;
    #2;
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero(0, "reset");
    check_all_zero(1, "reset");
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    for (int u = 0; u < 2; u++) begin
      starv[u] = 0; exp_ird[u] = '0; exp_drd[u] = '0;
    end
    @(negedge clk);
  endtask

  task automatic test_fetch_read;
    txn(0, 0, 32'h0000_0008, 32'h0, "fetch_lat1");
  endtask

  task automatic test_data_write;
    txn(0, 2, 32'h0000_0010, 32'd100, "dwrite");
  endtask

  task automatic test_starvation;
    run_seq(0, 10, 1'b1, "starve_l1");
    run_seq(1, 10, 1'b1, "starve_l3");
  endtask

  task automatic test_rw_both_wrap;
    txn(0, 1, 32'h0000_0030, 32'h0, "read_before_both");
    txn(0, 3, 32'h0000_0104, 32'hA5A5_0001, "rw_both_wrap");
    txn(0, 1, 32'h0000_0005, 32'h0, "readback_wrap");
  endtask

  task automatic test_lat3_read;
    txn(1, 1, 32'h0000_0024, 32'h0, "lat3_read");
    txn(1, 0, 32'hFFFF_FF3C, 32'h0, "lat3_fetch_wrap");
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    apply(1, 0, 1, 1, 0, 0, 32'h30, 0);
    @(negedge clk);
    @(negedge clk);
    nvec++;
    if (busy[1] !== 1'b1) begin
      nerr++;
      $display("FAIL async_reset pre: busy=%b, required 1", busy[1]);
    end
    #2;
    rst_n[1] = 1'b0;
    #1;
    check_all_zero(1, "async_reset");
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    starv[1] = 0; exp_ird[1] = '0; exp_drd[1] = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_all_zero(1, "in_reset");
    end
    rst_n[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      nvec++;
      if ((if_ready[1] | d_ready[1] | busy[1]) !== 1'b0) begin
        nerr++;
        $display("FAIL post_reset quiet: if=%b d=%b busy=%b, required 0", if_ready[1], d_ready[1], busy[1]);
      end
    end
    txn(1, 1, 32'h0000_0030, 32'h0, "post_reset_read");
  endtask

  task automatic test_back_to_back;
    run_seq(0, 60, 1'b0, "rand_l1");
    run_seq(1, 60, 1'b0, "rand_l3");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      for (int a = 0; a < 64; a++) ref_mem[u][a] = init_word(a);
      rst_n[u] = 1'b1;
      apply(u, 0, 0, 0, 0, 0, 0, 0);
      starv[u] = 0; exp_ird[u] = '0; exp_drd[u] = '0;
    end
    test_reset;
    test_fetch_read;
    test_data_write;
    test_starvation;
    test_rw_both_wrap;
    test_lat3_read;
    test_async_reset;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
